// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator: walks CHUNK-bit slices MSB-first,
// optionally stopping at the first differing slice. Start/busy/done handshake.
module serial_magnitude_comparator #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned CHUNK      = 4,
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               signed_mode,
    input  logic [WIDTH-1:0]                   a,
    input  logic [WIDTH-1:0]                   b,
    output logic                               busy,
    output logic                               done,
    output logic                               a_eq_b,
    output logic                               a_gt_b,
    output logic                               a_lt_b,
    output logic [$clog2(WIDTH/CHUNK+1)-1:0]   chunks_used
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CU_W   = $clog2(NCHUNK + 1);
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx;
    logic             diff_seen;
    logic             diff_gt;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic             chunk_diff;
    logic             chunk_gt;
    logic             any_diff;
    logic             first_gt;
    logic             finish_cmp;

    assign chunk_a = a_q[idx*CHUNK +: CHUNK];
    assign chunk_b = b_q[idx*CHUNK +: CHUNK];

    // The earliest (most significant) difference decides the ordering.
    always_comb begin
        chunk_diff = (chunk_a != chunk_b);
        chunk_gt   = (chunk_a > chunk_b);
        any_diff   = diff_seen || chunk_diff;
        first_gt   = diff_seen ? diff_gt : chunk_gt;
        finish_cmp = ((EARLY_EXIT != 0) && chunk_diff) || (idx == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CMP;
            S_CMP:   if (finish_cmp) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_CMP);
    assign done = (state == S_DONE);

    // Signed operands get their MSB flipped at capture so the unsigned walk orders them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            idx         <= '0;
            diff_seen   <= 1'b0;
            diff_gt     <= 1'b0;
            a_eq_b      <= 1'b0;
            a_gt_b      <= 1'b0;
            a_lt_b      <= 1'b0;
            chunks_used <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q         <= signed_mode ? (a ^ MSB_MASK) : a;
                        b_q         <= signed_mode ? (b ^ MSB_MASK) : b;
                        idx         <= IDX_W'(NCHUNK - 1);
                        diff_seen   <= 1'b0;
                        diff_gt     <= 1'b0;
                        a_eq_b      <= 1'b0;
                        a_gt_b      <= 1'b0;
                        a_lt_b      <= 1'b0;
                        chunks_used <= '0;
                    end
                end
                S_CMP: begin
                    chunks_used <= chunks_used + CU_W'(1);
                    if (finish_cmp) begin
                        a_eq_b <= !any_diff;
                        a_gt_b <= any_diff && first_gt;
                        a_lt_b <= any_diff && !first_gt;
                    end else begin
                        idx <= idx - IDX_W'(1);
                        if (chunk_diff && !diff_seen) begin
                            diff_seen <= 1'b1;
                            diff_gt   <= chunk_gt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed and randomised checks of serial_magnitude_comparator with early exit on and off,
// both instances driven by the same stimulus.
module tb_serial_magnitude_comparator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_mode;
    logic [15:0] a;
    logic [15:0] b;

    logic        busy_e, done_e, eq_e, gt_e, lt_e;
    logic [2:0]  cu_e;
    logic        busy_n, done_n, eq_n, gt_n, lt_n;
    logic [2:0]  cu_n;
    logic [2:0]  fl_e;
    logic [2:0]  fl_n;

    int total = 0;
    int bad   = 0;
    int edges_e;
    int edges_n;

    assign fl_e = {eq_e, gt_e, lt_e};
    assign fl_n = {eq_n, gt_n, lt_n};

    serial_magnitude_comparator #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy_e), .done(done_e),
        .a_eq_b(eq_e), .a_gt_b(gt_e), .a_lt_b(lt_e), .chunks_used(cu_e)
    );

    serial_magnitude_comparator #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy_n), .done(done_n),
        .a_eq_b(eq_n), .a_gt_b(gt_n), .a_lt_b(lt_n), .chunks_used(cu_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            assert (!(busy_e && done_e) && !(busy_n && done_n)) else begin
                bad++;
                $error("FAIL busy_done_overlap observed=%0b%0b%0b%0b expected=no overlap",
                       busy_e, done_e, busy_n, done_n);
            end
        end
    end

    // One handshake: capture, wait (bounded) for both done pulses, then one idle edge.
    task automatic run(input logic sm, input logic [15:0] av, input logic [15:0] bv,
                       input bit disturb);
        int nd_e;
        nd_e    = 0;
        edges_e = 0;
        edges_n = 0;
        a = av; b = bv; signed_mode = sm; start = 1'b1;
        @(posedge clk); #1;
        start = disturb;
        chk("busy_after_capture", 32'({busy_e, busy_n}), 'b11);
        chk("flags_clear_while_busy", 32'({fl_e, fl_n}), 0);
        for (int i = 1; i <= 8 && edges_n == 0; i++) begin
            if (disturb) begin
                a = ~a;
                b = b + 16'h1111;
                signed_mode = ~signed_mode;
            end
            @(posedge clk); #1;
            if (done_e) begin
                nd_e++;
                if (edges_e == 0) edges_e = i;
            end
            if (done_n) begin
                edges_n = i;
                start = 1'b0;
            end
        end
        chk("done_seen", 32'(edges_e != 0 && edges_n != 0), 1);
        chk("done_pulses_e", 32'(nd_e), 1);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'({done_e, done_n, busy_e, busy_n}), 0);
    endtask

    logic [15:0] ra, rb, dx;
    logic        rs;
    logic [2:0]  exp_fl;
    int          exp_k;
    int          seen;

    initial begin
        rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        #1;
        chk("reset_outputs_e", 32'({busy_e, done_e, fl_e, cu_e}), 0);
        chk("reset_outputs_n", 32'({busy_n, done_n, fl_n, cu_n}), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Equal operands walk all four chunks.
        run(1'b0, 16'h1234, 16'h1234, 1'b0);
        chk("t1_flags_e", 32'(fl_e), 'b100);
        chk("t1_cu_e", 32'(cu_e), 4);
        chk("t1_edges_e", 32'(edges_e), 4);
        chk("t1_flags_n", 32'(fl_n), 'b100);
        chk("t1_cu_n", 32'(cu_n), 4);

        // Top chunk differs.
        run(1'b0, 16'h9000, 16'h1FFF, 1'b0);
        chk("t2_flags_e", 32'(fl_e), 'b010);
        chk("t2_cu_e", 32'(cu_e), 1);
        chk("t2_edges_e", 32'(edges_e), 1);
        chk("t2_flags_n", 32'(fl_n), 'b010);
        chk("t2_cu_n", 32'(cu_n), 4);

        run(1'b1, 16'h8000, 16'h0001, 1'b0);
        chk("t3s_flags_e", 32'(fl_e), 'b001);
        chk("t3s_cu_e", 32'(cu_e), 1);
        chk("t3s_flags_n", 32'(fl_n), 'b001);
        run(1'b0, 16'h8000, 16'h0001, 1'b0);
        chk("t3u_flags_e", 32'(fl_e), 'b010);
        chk("t3u_flags_n", 32'(fl_n), 'b010);
        run(1'b1, 16'h7FFF, 16'h8000, 1'b0);
        chk("t3b_flags_e", 32'(fl_e), 'b010);
        chk("t3b_cu_e", 32'(cu_e), 1);

        // Difference in chunk 2 of 4.
        run(1'b0, 16'h0100, 16'h0200, 1'b0);
        chk("t4_flags_n", 32'(fl_n), 'b001);
        chk("t4_cu_n", 32'(cu_n), 4);
        chk("t4_edges_n", 32'(edges_n), 4);
        chk("t4_flags_e", 32'(fl_e), 'b001);
        chk("t4_cu_e", 32'(cu_e), 2);
        chk("t4_edges_e", 32'(edges_e), 2);
        a = 16'hFFFF; b = 16'h0000; signed_mode = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_hold_n", 32'({fl_n, cu_n}), 32'({3'b001, 3'd4}));
        chk("t4_hold_e", 32'({fl_e, cu_e}), 32'({3'b001, 3'd2}));

        // start and operands toggled throughout the compare.
        run(1'b0, 16'h1234, 16'h1234, 1'b1);
        chk("t5_disturb_flags_e", 32'(fl_e), 'b100);
        chk("t5_disturb_flags_n", 32'(fl_n), 'b100);
        chk("t5_disturb_cu_e", 32'(cu_e), 4);

        // Reset two edges into a compare.
        a = 16'h1234; b = 16'h1235; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_e", 32'({busy_e, done_e, fl_e, cu_e}), 0);
        chk("t5_rst_n", 32'({busy_n, done_n, fl_n, cu_n}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done_e || done_n || busy_e || busy_n) seen++;
        end
        chk("t5_no_done_after_rst", 32'(seen), 0);
        run(1'b1, 16'hFFFE, 16'h0003, 1'b0);
        chk("t5_after_rst_flags_e", 32'(fl_e), 'b001);
        chk("t5_after_rst_cu_e", 32'(cu_e), 1);
        chk("t5_after_rst_flags_n", 32'(fl_n), 'b001);

        for (int v = 0; v < 1000; v++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case (v % 4)
                0: rb = ra;
                1: rb = ra ^ (16'h1 << $urandom_range(0, 15));
                default: ;
            endcase
            rs = 1'($urandom_range(0, 1));
            if (rs) begin
                if ($signed(ra) > $signed(rb))      exp_fl = 3'b010;
                else if ($signed(ra) < $signed(rb)) exp_fl = 3'b001;
                else                                exp_fl = 3'b100;
            end else begin
                if (ra > rb)      exp_fl = 3'b010;
                else if (ra < rb) exp_fl = 3'b001;
                else              exp_fl = 3'b100;
            end
            dx = ra ^ rb;
            exp_k = 4;
            for (int c = 0; c < 4; c++) begin
                if (dx[(3 - c) * 4 +: 4] != 4'h0) begin
                    exp_k = c + 1;
                    break;
                end
            end
            run(rs, ra, rb, 1'b0);
            chk("rnd_flags_e", 32'(fl_e), 32'(exp_fl));
            chk("rnd_flags_n", 32'(fl_n), 32'(exp_fl));
            chk("rnd_onehot", 32'($onehot(fl_e) && $onehot(fl_n)), 1);
            chk("rnd_cu_e", 32'(cu_e), 32'(exp_k));
            chk("rnd_edges_e", 32'(edges_e), 32'(exp_k));
            chk("rnd_cu_n", 32'(cu_n), 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
